// File: rtl/quad_decoder.sv
// Quadrature A/B encoder decoder: synchronizes and debounces both phases, then
// emits one-cycle step pulses with direction, a wrapping position and a sticky error.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned POS_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_pos,
  input  logic             err_clr,
  output logic             ready,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             err
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned INIT_W = 2;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILTER_LEN - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(2);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Channel vectors: bit 1 = phase A, bit 0 = phase B.
  logic [1:0]            s1, s2;
  logic [1:0]            filt, filt_nxt;
  logic [1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]            hit;
  logic [INIT_W-1:0]     init_cnt, init_cnt_nxt;
  logic                  fwd;
  logic                  ready_nxt, step_nxt, dir_nxt, err_nxt;
  logic [POS_W-1:0]      pos_nxt;

  // Two-flop synchronizer on the raw phase pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {a_in, b_in};
      s2 <= s1;
    end
  end

  // Per-channel debounce: filt follows s2 only after FILTER_LEN differing edges.
  always_comb begin
    hit     = 2'b00;
    cnt_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (state == ST_RUN) begin
        hit[i] = (s2[i] != filt[i]) && (cnt[i] == CNT_LAST);
        if ((s2[i] == filt[i]) || hit[i]) begin
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A single-channel change is forward when it follows 00->01->11->10->00.
  always_comb begin
    fwd = 1'b0;
    case ({filt, filt ^ hit})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
      default:                                fwd = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM output logic: next values for every registered output and filt.
  always_comb begin
    init_cnt_nxt = init_cnt;
    filt_nxt     = filt;
    ready_nxt    = ready;
    step_nxt     = 1'b0;
    dir_nxt      = dir;
    pos_nxt      = pos;
    err_nxt      = err;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) begin
          filt_nxt  = s2;
          ready_nxt = 1'b1;
        end else begin
          init_cnt_nxt = init_cnt + INIT_W'(1);
        end
      end
      ST_RUN: begin
        filt_nxt = filt ^ hit;
        if (hit == 2'b11) begin
          err_nxt = 1'b1;
        end else begin
          if (err_clr) err_nxt = 1'b0;
          if ((hit != 2'b00) && en) begin
            step_nxt = 1'b1;
            dir_nxt  = fwd;
            pos_nxt  = fwd ? pos + POS_W'(1) : pos - POS_W'(1);
          end
        end
      end
      default: ;
    endcase
    // Clear wins over a same-edge count; step/dir still report it.
    if (clr_pos) pos_nxt = '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      filt     <= 2'b00;
      cnt      <= '0;
      ready    <= 1'b0;
      step     <= 1'b0;
      dir      <= 1'b0;
      pos      <= '0;
      err      <= 1'b0;
    end else begin
      init_cnt <= init_cnt_nxt;
      filt     <= filt_nxt;
      cnt      <= cnt_nxt;
      ready    <= ready_nxt;
      step     <= step_nxt;
      dir      <= dir_nxt;
      pos      <= pos_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a Gray-sequence model pushes expected steps
// (dir, pos, cycle) to a scoreboard that is checked every cycle.
module tb_quad_decoder;

  localparam int unsigned FL = 3;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst, en, a_in, b_in, clr_pos, err_clr;
  logic          ready, step, dir, err;
  logic [PW-1:0] pos;

  always #5 clk = ~clk;

  quad_decoder #(.FILTER_LEN(FL), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in),
    .clr_pos(clr_pos), .err_clr(err_clr), .ready(ready), .step(step),
    .dir(dir), .pos(pos), .err(err)
  );

  typedef struct {
    logic          dir;
    logic [PW-1:0] pos;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [1:0]    m_ab;
  logic [PW-1:0] m_pos;
  logic          m_err;
  logic [1:0]    gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int gidx(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (gray[i] == v) return i;
    return 0;
  endfunction

  function automatic logic [1:0] next_fwd(input logic [1:0] v);
    return gray[2'((gidx(v) + 1) % 4)];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle; sample at the falling edge and settle the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("step_pulse", 32'(step), 32'd1);
      check("step_dir", 32'(dir), 32'(e.dir));
      check("step_pos", 32'(pos), 32'(e.pos));
    end else begin
      check("no_step", 32'(step), 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive a new level, predict its effect, optionally pulse clr_pos/err_clr on the update edge.
  task automatic drive(input logic [1:0] ab, input int hold, input logic pclr, input logic perr);
    exp_t e;
    logic f;
    int   k = cyc;
    a_in = ab[1];
    b_in = ab[0];
    if (ab != m_ab) begin
      if ((ab ^ m_ab) == 2'b11) begin
        m_err = 1'b1;
      end else begin
        if (perr) m_err = 1'b0;
        if (en) begin
          f     = (gidx(ab) == ((gidx(m_ab) + 1) % 4));
          m_pos = f ? m_pos + PW'(1) : m_pos - PW'(1);
          if (pclr) m_pos = '0;
          e.dir = f;
          e.pos = m_pos;
          e.cyc = k + 2 + int'(FL);
          sb.push_back(e);
        end
      end
    end
    m_ab = ab;
    for (int i = 0; i < hold; i++) begin
      if (i == int'(FL) + 1) begin
        clr_pos = pclr;
        err_clr = perr;
      end
      if (i == int'(FL) + 2) begin
        clr_pos = 1'b0;
        err_clr = 1'b0;
      end
      tick();
    end
  endtask

  task automatic do_reset(input logic [1:0] ab);
    a_in = ab[1];
    b_in = ab[0];
    rst  = 1'b1;
    ticks(3);
    check("rst_sb_empty", 32'(sb.size()), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    rst   = 1'b0;
    m_ab  = ab;
    m_pos = '0;
    m_err = 1'b0;
    tick();
    check("init_ready_1", 32'(ready), 32'd0);
    tick();
    check("init_ready_2", 32'(ready), 32'd0);
    tick();
    check("init_ready_3", 32'(ready), 32'd1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pos"}, 32'(pos), 32'(m_pos));
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; a_in = 1'b1; b_in = 1'b1;
    clr_pos = 1'b0; err_clr = 1'b0;
    m_ab = 2'b11; m_pos = '0; m_err = 1'b0;

    // Power-up with both phases high, then a forward step out of 11.
    do_reset(2'b11);
    ticks(10);
    check_state("init11");
    drive(2'b10, 8, 1'b0, 1'b0);
    check_state("first_step");

    // Reset arriving on the would-be update edge aborts the step.
    a_in = 1'b1; b_in = 1'b1;
    ticks(4);
    rst = 1'b1;
    tick();
    do_reset(2'b00);

    // One full forward cycle.
    drive(2'b01, 8, 1'b0, 1'b0);
    drive(2'b11, 8, 1'b0, 1'b0);
    drive(2'b10, 8, 1'b0, 1'b0);
    drive(2'b00, 8, 1'b0, 1'b0);
    check_state("fwd_cycle");
    check("fwd_cycle_dir", 32'(dir), 32'd1);

    // Underflow then 256 forward steps back around.
    clr_pos = 1'b1;
    tick();
    clr_pos = 1'b0;
    m_pos = '0;
    check_state("clr_pos");
    drive(2'b10, 8, 1'b0, 1'b0);
    check_state("underflow");
    check("underflow_dir", 32'(dir), 32'd0);
    for (int i = 0; i < 256; i++) drive(next_fwd(m_ab), 5, 1'b0, 1'b0);
    check_state("wrap256");
    check("wrap256_dir", 32'(dir), 32'd1);

    // Two-cycle glitch is rejected; three-cycle pulse is accepted both ways.
    a_in = 1'b0;
    ticks(2);
    a_in = 1'b1;
    ticks(8);
    check_state("glitch2");
    drive(2'b00, 3, 1'b0, 1'b0);
    drive(2'b10, 8, 1'b0, 1'b0);
    check_state("pulse3");

    // Illegal two-bit jump, resync, clear, and set-wins-over-clear.
    drive(2'b00, 8, 1'b0, 1'b0);
    drive(2'b11, 8, 1'b0, 1'b0);
    check_state("jump_err");
    drive(2'b10, 8, 1'b0, 1'b0);
    check_state("resync");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    check_state("err_clr");
    drive(2'b01, 8, 1'b0, 1'b1);
    check_state("err_set_wins");

    // Disabled: filters track, no steps, err still detected.
    en = 1'b0;
    drive(2'b11, 8, 1'b0, 1'b0);
    drive(2'b10, 8, 1'b0, 1'b0);
    drive(2'b00, 8, 1'b0, 1'b0);
    check_state("en_off");
    check("en_off_dir", 32'(dir), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    drive(2'b11, 8, 1'b0, 1'b0);
    check_state("en_off_err");

    // Re-enable: no catch-up step; clr_pos coincident with a step.
    en = 1'b1;
    ticks(10);
    check_state("reenable");
    drive(2'b10, 8, 1'b1, 1'b0);
    check_state("clr_with_step");
    drive(2'b00, 8, 1'b0, 1'b0);
    check_state("after_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B phase) rotary-encoder decoder.
- Turns two asynchronous phase inputs into single-cycle step pulses with direction, plus a wrapping position count and a sticky sequence-error flag.
- Its step/dir outputs drive the start/up controls of the team's up/down counter, so it is the producing end of that count-control interface.
- Sits at the board I/O boundary, between encoder pins and counter/CPU-visible logic.

Parameters:
- FILTER_LEN, 3: consecutive clock edges a synchronized phase must differ from its filtered value before the filtered value is updated. Legal range 1..15.
- POS_W, 8: width of the position count.

Ports:
- clk  input  1  system clock, all state on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step/position enable.
- a_in  input  1  encoder phase A, asynchronous.
- b_in  input  1  encoder phase B, asynchronous.
- clr_pos  input  1  synchronous clear of pos.
- err_clr  input  1  clears err.
- ready  output  1  high once the decoder is in RUN.
- step  output  1  one-cycle pulse per valid quadrature transition.
- dir  output  1  direction of the last valid step: 1 = forward/up, 0 = reverse/down.
- pos  output  POS_W  signed-agnostic position, wraps modulo 2^POS_W.
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset:
  - s1/s2 sync flops, filt_a/filt_b, filter counters, step, dir, pos, err and ready all go to 0.
  - State goes to INIT with init_cnt = 0.
  - Reset mid-operation aborts everything the same way; no step is emitted on the reset edge.
- Synchronizer: each phase passes through 2 flops, s1 then s2. Filtering uses only s2.
- Filter, per channel, independent:
  - If s2 == filt, cnt <= 0.
  - Otherwise cnt increments.
  - On the edge where cnt == FILTER_LEN-1 and s2 != filt: filt <= s2 and cnt <= 0.
  - Any bounce back to filt restarts the count.
- State machine:
  - INIT: init_cnt counts 0,1,2. On the edge with init_cnt == 2, filt_a/filt_b load s2 directly, with no step and no err. Then go to RUN and set ready = 1.
  - RUN: decode. Stays in RUN until rst.
- Decode in RUN, evaluated on the edge where a filtered value updates; old = {filt_a, filt_b}, new = next value.
  - Forward Gray sequence 00->01->11->10->00: step <= 1, dir <= 1, pos <= pos+1.
  - Reverse sequence 00->10->11->01->00: step <= 1, dir <= 0, pos <= pos-1.
  - Both channels update on the same edge (2-bit jump): err <= 1, no step, pos and dir unchanged. Both filt values still update, so decoding resyncs.
  - step is high exactly one cycle, in the cycle after the updating edge. It is 0 otherwise.
- Latency:
  - A clean raw edge captured into s1 at edge N updates filt at edge N+1+FILTER_LEN.
  - step, dir and pos are visible after that same edge.
  - With default FILTER_LEN = 3, step is high in the cycle after edge N+4.
- Width: pos arithmetic is modulo 2^POS_W. 0-1 gives all-ones; all-ones+1 gives 0.
- en = 0:
  - Synchronizer, filters and filt keep tracking.
  - step is forced 0; pos and dir are held.
  - err detection still operates.
  - Re-enabling never produces a catch-up step.
- clr_pos:
  - pos <= 0, taking priority over a same-edge increment or decrement.
  - step and dir still report that transition normally.
- err_clr:
  - err <= 0.
  - If an illegal transition is detected on the same edge, set wins and err stays 1.
- Unlisted conditions (en, clr_pos, err_clr in INIT): ignored except clr_pos, which clears pos.

Test Plan:
- Reset then a_in = b_in = 1 held → ready rises after the 3rd post-reset edge; step and err stay 0; filt = 11.
- From 00, drive one full forward cycle 01, 11, 10, 00, each level held 8 cycles, FILTER_LEN = 3 → exactly 4 step pulses with dir = 1, pos = 4. Each pulse appears 4 edges after the level is captured in s1.
- From pos = 0, a reverse sequence of 1 step (00->10) → pos = 8'hFF, dir = 0. Then 256 forward steps → pos returns to 8'hFF.
- Glitch: a_in toggles for 2 cycles then returns, FILTER_LEN = 3 → no step, pos unchanged. Toggle held for 3 cycles → one step.
- Both a_in and b_in flip 00→11 on the same cycle → err = 1, no step, pos unchanged. Next legal transition 11→10 steps forward. err_clr pulse clears err; err_clr coincident with another 2-bit jump leaves err = 1.
- en = 0 during 3 forward transitions → no step and pos held. Re-enable → no step until the next transition. clr_pos on the same edge as a forward step → pos = 0 and step = 1.
